// File: rtl/ps2_device_emu.sv
// PS/2 device-side emulator: sends FIFO bytes to the host and receives host command bytes with ACK.
// Optional `PS2_AUTO_ACK_EN: each good host byte gets an automatic 0xFA/0xEE (+0xAA after 0xFF) reply.
`timescale 1ns/1ps
module ps2_device_emu #(
  parameter int CLK_HZ     = 80000000,
  parameter int PS2_HZ     = 12500,
  parameter int FIFO_DEPTH = 8
) (
  input  logic       clk_cog,
  input  logic       nres,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_err,
  input  logic       ps2_clk_in,
  output logic       ps2_clk_oe,
  input  logic       ps2_data_in,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic [1:0] state_dbg
);
  // tx_valid/tx_ready: a byte is taken on every rising clk_cog edge where both are high; tx_ready means FIFO not full.
  localparam int HALF = CLK_HZ / (2 * PS2_HZ);
  localparam int TW   = $clog2(2 * HALF + 1);
  localparam int AW   = $clog2(FIFO_DEPTH);

  localparam logic [TW-1:0] T_HALF_M1 = TW'(HALF - 1);
  localparam logic [TW-1:0] T_QTR     = TW'(HALF / 2);
  localparam logic [TW-1:0] T_GAP     = TW'(2 * HALF);
  localparam logic [TW-1:0] T_SETTLE  = TW'(4);

  typedef enum logic [1:0] {S_IDLE, S_TX, S_INHIBIT, S_RX} state_t;

  state_t        state;
  logic [TW-1:0] timer;
  logic [3:0]    bit_cnt;
  logic          phase_low;
  logic [10:0]   frame;
  logic [9:0]    rx_shift;
  logic          rx_good;
  logic          inh_rts;

  logic [1:0] clk_sync, data_sync;
  logic       clk_s, data_s;

  logic [7:0]  mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic        empty, full, push;

  logic       have_tx;
  logic [7:0] next_byte;

`ifdef PS2_AUTO_ACK_EN
  logic [1:0] ack_cnt;
  logic [7:0] ack_b0, ack_b1;
  logic       next_is_ack, tx_from_ack;
`endif

  // Synchronisers idle high so an idle bus is never mistaken for an inhibit.
  always_ff @(posedge clk_cog or negedge nres) begin
    if (!nres) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk_in};
      data_sync <= {data_sync[0], ps2_data_in};
    end
  end
  assign clk_s  = clk_sync[1];
  assign data_s = data_sync[1];

  assign count    = wr_ptr - rd_ptr;
  assign empty    = (count == '0);
  assign full     = (count == (AW+1)'(FIFO_DEPTH));
  assign tx_ready = !full;
  assign push     = tx_valid && tx_ready;

  always_ff @(posedge clk_cog) begin
    if (push) mem[wr_ptr[AW-1:0]] <= tx_data;
  end

  always_ff @(posedge clk_cog or negedge nres) begin
    if (!nres) wr_ptr <= '0;
    else if (push) wr_ptr <= wr_ptr + 1'b1;
  end

  always_comb begin
    next_byte = mem[rd_ptr[AW-1:0]];
    have_tx   = !empty;
`ifdef PS2_AUTO_ACK_EN
    next_is_ack = 1'b0;
    if (ack_cnt != 2'd0) begin
      next_byte   = ack_b0;
      next_is_ack = 1'b1;
      have_tx     = 1'b1;
    end
`endif
  end

`ifdef PS2_AUTO_ACK_EN
  assign busy = (state != S_IDLE) || !empty || (ack_cnt != 2'd0);
`else
  assign busy = (state != S_IDLE) || !empty;
`endif
  assign state_dbg = state;

  always_ff @(posedge clk_cog or negedge nres) begin
    if (!nres) begin
      state       <= S_IDLE;
      timer       <= '0;
      bit_cnt     <= '0;
      phase_low   <= 1'b0;
      frame       <= '0;
      rx_shift    <= '0;
      rx_good     <= 1'b0;
      inh_rts     <= 1'b0;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      rx_err      <= 1'b0;
      rd_ptr      <= '0;
`ifdef PS2_AUTO_ACK_EN
      ack_cnt     <= '0;
      ack_b0      <= '0;
      ack_b1      <= '0;
      tx_from_ack <= 1'b0;
`endif
    end else begin
      rx_valid <= 1'b0;
      rx_err   <= 1'b0;
      case (state)
        S_IDLE: begin
          ps2_clk_oe  <= 1'b0;
          ps2_data_oe <= 1'b0;
          if (timer != T_GAP) timer <= timer + 1'b1;
          // The settle guard hides the synchroniser lag right after we release the clock.
          if (!clk_s && timer >= T_SETTLE) begin
            state   <= S_INHIBIT;
            inh_rts <= 1'b0;
            timer   <= '0;
          end else if (have_tx && timer == T_GAP) begin
            state     <= S_TX;
            frame     <= {1'b1, ~^next_byte, next_byte, 1'b0};
            bit_cnt   <= '0;
            phase_low <= 1'b0;
            timer     <= '0;
`ifdef PS2_AUTO_ACK_EN
            tx_from_ack <= next_is_ack;
`endif
          end
        end

        S_TX: begin
          if (!phase_low) begin
            if (!clk_s && timer >= T_SETTLE && bit_cnt <= 4'd9) begin
              ps2_clk_oe  <= 1'b0;
              ps2_data_oe <= 1'b0;
              state       <= S_INHIBIT;
              inh_rts     <= 1'b0;
              timer       <= '0;
            end else if (timer == T_HALF_M1) begin
              timer <= '0;
              if (bit_cnt == 4'd11) begin
                state <= S_IDLE;
`ifdef PS2_AUTO_ACK_EN
                if (tx_from_ack) begin
                  ack_b0  <= ack_b1;
                  ack_cnt <= ack_cnt - 1'b1;
                end else begin
                  rd_ptr <= rd_ptr + 1'b1;
                end
`else
                rd_ptr <= rd_ptr + 1'b1;
`endif
              end else begin
                phase_low  <= 1'b1;
                ps2_clk_oe <= 1'b1;
              end
            end else begin
              timer <= timer + 1'b1;
              if (timer == T_QTR && bit_cnt <= 4'd10) ps2_data_oe <= ~frame[bit_cnt];
            end
          end else if (timer == T_HALF_M1) begin
            timer      <= '0;
            phase_low  <= 1'b0;
            ps2_clk_oe <= 1'b0;
            bit_cnt    <= bit_cnt + 4'd1;
          end else begin
            timer <= timer + 1'b1;
          end
        end

        S_INHIBIT: begin
          ps2_clk_oe  <= 1'b0;
          ps2_data_oe <= 1'b0;
          if (!inh_rts) begin
            if (clk_s) begin
              timer <= '0;
              if (!data_s) inh_rts <= 1'b1;
              else state <= S_IDLE;
            end
          end else if (timer == T_HALF_M1) begin
            state      <= S_RX;
            timer      <= '0;
            bit_cnt    <= '0;
            phase_low  <= 1'b1;
            ps2_clk_oe <= 1'b1;
            rx_good    <= 1'b0;
          end else begin
            timer <= timer + 1'b1;
          end
        end

        S_RX: begin
          // Lead-in low, then ten high/low clocks sampling bits, then one ACK clock (bit_cnt 10 high, 11 low).
          if (timer == T_HALF_M1) begin
            timer <= '0;
            if (phase_low) begin
              if (bit_cnt == 4'd11) begin
                ps2_clk_oe  <= 1'b0;
                ps2_data_oe <= 1'b0;
                state       <= S_IDLE;
                if (rx_good) begin
                  rx_valid <= 1'b1;
                  rx_data  <= rx_shift[7:0];
`ifdef PS2_AUTO_ACK_EN
                  ack_b1 <= 8'hAA;
                  if (rx_shift[7:0] == 8'hFF) begin
                    ack_cnt <= 2'd2;
                    ack_b0  <= 8'hFA;
                  end else begin
                    ack_cnt <= 2'd1;
                    ack_b0  <= (rx_shift[7:0] == 8'hEE) ? 8'hEE : 8'hFA;
                  end
`endif
                end else begin
                  rx_err <= 1'b1;
                end
              end else begin
                phase_low  <= 1'b0;
                ps2_clk_oe <= 1'b0;
              end
            end else begin
              if (bit_cnt == 4'd9) rx_good <= rx_shift[9] && (^rx_shift[8:0]);
              phase_low  <= 1'b1;
              ps2_clk_oe <= 1'b1;
              bit_cnt    <= bit_cnt + 4'd1;
            end
          end else begin
            timer <= timer + 1'b1;
            if (!phase_low && timer == T_QTR) begin
              if (bit_cnt <= 4'd9) rx_shift <= {data_s, rx_shift[9:1]};
              else if (rx_good) ps2_data_oe <= 1'b1;
            end
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ps2_device_emu.sv
// Bench for ps2_device_emu: pulled-up open-drain bus, host model, frame scoreboard.
`timescale 1ns/1ps
module tb_ps2_device_emu;
  localparam int CLK_HZ = 1000000;
  localparam int PS2_HZ = 12500;
  localparam int HALF   = 40;
  localparam int DEPTH  = 8;

  logic       clk_cog = 1'b0;
  logic       nres;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid, rx_err;
  logic       ps2_clk_oe, ps2_data_oe;
  logic       busy;
  logic [1:0] state_dbg;

  logic host_clk_drv, host_data_drv, host_rx_mode;
  logic bus_clk, bus_data;
  assign bus_clk  = ~(ps2_clk_oe | host_clk_drv);
  assign bus_data = ~(ps2_data_oe | host_data_drv);

  ps2_device_emu #(.CLK_HZ(CLK_HZ), .PS2_HZ(PS2_HZ), .FIFO_DEPTH(DEPTH)) dut (
    .clk_cog(clk_cog), .nres(nres), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_err(rx_err),
    .ps2_clk_in(bus_clk), .ps2_clk_oe(ps2_clk_oe), .ps2_data_in(bus_data), .ps2_data_oe(ps2_data_oe),
    .busy(busy), .state_dbg(state_dbg)
  );

  // clock/reset block
  always #5 clk_cog = ~clk_cog;
  int cyc = 0;
  always @(posedge clk_cog) cyc++;

  initial begin
    #600000;
    $display("FAIL watchdog: time limit reached, expected finish earlier");
    $fatal(1, "watchdog");
  end

  // scoreboard
  logic [10:0] exp_q[$];
  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [10:0] frame_of(input logic [7:0] b);
    return {1'b1, ~^b, b, 1'b0};
  endfunction

  // device-to-host frame monitor
  logic [10:0] mon_frame = '0;
  int  mon_cnt = 0, last_fall = 0, last_end = 0, frames_seen = 0;
  bit  have_end = 0;
  always @(negedge bus_clk) begin
    if (!host_clk_drv && !host_rx_mode) begin
      if (cyc - last_fall > 3 * HALF) mon_cnt = 0;
      last_fall = cyc;
      if (mon_cnt == 0 && have_end) check("frame_gap", int'(cyc - last_end >= 4 * HALF), 1);
      mon_frame[mon_cnt] = bus_data;
      mon_cnt++;
      if (mon_cnt == 11) begin
        mon_cnt = 0;
        frames_seen++;
        have_end = 1;
        last_end = cyc;
        check("frame_expected", int'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) check("frame_bits", int'(mon_frame), int'(exp_q.pop_front()));
      end
    end
  end

  int rxv_cnt = 0, rxe_cnt = 0;
  always @(negedge clk_cog) begin
    if (rx_valid) rxv_cnt++;
    if (rx_err) rxe_cnt++;
  end

  // driver tasks
  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk_cog);
  endtask

  task automatic push(input logic [7:0] b, input bit expect_accept);
    @(negedge clk_cog);
    check("tx_ready_at_push", int'(tx_ready), int'(expect_accept));
    tx_data  = b;
    tx_valid = 1'b1;
    if (expect_accept) exp_q.push_back(frame_of(b));
    @(negedge clk_cog);
    tx_valid = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int k;
    for (k = 0; k < budget && exp_q.size() != 0; k++) @(negedge clk_cog);
    check("drain_left", exp_q.size(), 0);
    wait_cycles(2 * HALF + 10);
  endtask

  task automatic wait_bus_fall(input string tag);
    logic prev;
    bit   seen;
    prev = bus_clk;
    seen = 0;
    for (int k = 0; k < 4 * HALF && !seen; k++) begin
      @(negedge clk_cog);
      if (prev && !bus_clk) seen = 1;
      prev = bus_clk;
    end
    if (!seen) check(tag, int'(seen), 1);
  endtask

  task automatic wait_mon_cnt(input int target);
    int k;
    for (k = 0; k < 20 * HALF * 11 && mon_cnt != target; k++) @(negedge clk_cog);
    check("mon_cnt_reach", mon_cnt, target);
  endtask

  task automatic host_send(input logic [7:0] b, input logic par, input bit good);
    logic [9:0] bits;
    bits = {1'b1, par, b};
    host_rx_mode  = 1'b1;
    host_clk_drv  = 1'b1;
    wait_cycles(150);
    host_data_drv = 1'b1;
    wait_cycles(20);
    host_clk_drv  = 1'b0;
    for (int i = 0; i < 10; i++) begin
      wait_bus_fall("rx_clk_timeout");
      host_data_drv = ~bits[i];
    end
    wait_bus_fall("rx_clk_timeout");
    for (int k = 0; k < 2 * HALF && !bus_clk; k++) @(negedge clk_cog);
    wait_cycles(HALF / 2 + 5);
    check("ack_high_phase", int'(bus_data), good ? 0 : 1);
    wait_bus_fall("ack_clk_timeout");
    wait_cycles(5);
    check("ack_low_phase", int'(bus_data), good ? 0 : 1);
    wait_cycles(2 * HALF);
    host_rx_mode = 1'b0;
  endtask

  initial begin
    int f0, v0, e0;
    nres = 1'b0; tx_data = '0; tx_valid = 1'b0;
    host_clk_drv = 1'b0; host_data_drv = 1'b0; host_rx_mode = 1'b0;
    wait_cycles(5);
    check("rst_clk_oe", int'(ps2_clk_oe), 0);
    check("rst_data_oe", int'(ps2_data_oe), 0);
    check("rst_tx_ready", int'(tx_ready), 1);
    check("rst_rx_valid", int'(rx_valid), 0);
    check("rst_rx_err", int'(rx_err), 0);
    check("rst_rx_data", int'(rx_data), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_state", int'(state_dbg), 0);
    nres = 1'b1;
    wait_cycles(3 * HALF);

    // single byte, host passive
    f0 = frames_seen;
    push(8'h1C, 1);
    wait_drain(3000);
    check("t1_frames", frames_seen - f0, 1);
    check("t1_busy", int'(busy), 0);
    check("t1_tx_ready", int'(tx_ready), 1);

    // back-to-back bytes
    f0 = frames_seen;
    push(8'hF0, 1); push(8'h1C, 1); push(8'h55, 1);
    check("t2_tx_ready", int'(tx_ready), 1);
    wait_drain(6000);
    check("t2_frames", frames_seen - f0, 3);

    // FIFO fill while host inhibits
    host_clk_drv = 1'b1;
    wait_cycles(20);
    f0 = frames_seen;
    for (int i = 0; i < DEPTH; i++) push(8'(8'h30 + i), 1);
    check("t3_full", int'(tx_ready), 0);
    push(8'h99, 0);
    check("t3_busy", int'(busy), 1);
    wait_cycles(50);
    host_clk_drv = 1'b0;
    wait_drain(15000);
    wait_cycles(400);
    check("t3_frames", frames_seen - f0, DEPTH);
    check("t3_empty", int'(tx_ready), 1);

    // host aborts mid-frame; byte resent in full once
    f0 = frames_seen;
    push(8'hAB, 1);
    wait_mon_cnt(5);
    for (int k = 0; k < 2 * HALF && !bus_clk; k++) @(negedge clk_cog);
    wait_cycles(10);
    host_clk_drv = 1'b1;
    wait_cycles(10);
    check("t4_clk_released", int'(ps2_clk_oe), 0);
    check("t4_data_released", int'(ps2_data_oe), 0);
    check("t4_not_popped", int'(busy), 1);
    wait_cycles(200);
    host_clk_drv = 1'b0;
    wait_drain(3000);
    wait_cycles(400);
    check("t4_frames", frames_seen - f0, 1);

    // host-to-device good byte
    v0 = rxv_cnt; e0 = rxe_cnt;
`ifdef PS2_AUTO_ACK_EN
    exp_q.push_back(frame_of(8'hFA));
`endif
    host_send(8'hED, 1'b1, 1);
    check("t5_rx_valid_cycles", rxv_cnt - v0, 1);
    check("t5_rx_err", rxe_cnt - e0, 0);
    check("t5_rx_data", int'(rx_data), 'hED);
    wait_drain(3000);

    // host-to-device bad parity
    v0 = rxv_cnt; e0 = rxe_cnt;
    host_send(8'hED, 1'b0, 0);
    check("t6_rx_err_cycles", rxe_cnt - e0, 1);
    check("t6_rx_valid", rxv_cnt - v0, 0);
    check("t6_rx_data_kept", int'(rx_data), 'hED);
    wait_cycles(3 * HALF);

    // reset mid-TX
    f0 = frames_seen;
    push(8'h5A, 1);
    wait_mon_cnt(3);
    wait_cycles(HALF / 2);
    nres = 1'b0;
    #1;
    check("t6_rst_clk_oe", int'(ps2_clk_oe), 0);
    check("t6_rst_data_oe", int'(ps2_data_oe), 0);
    exp_q.delete();
    wait_cycles(3);
    nres = 1'b1;
    wait_cycles(2);
    check("t6_rst_busy", int'(busy), 0);
    check("t6_rst_tx_ready", int'(tx_ready), 1);
    check("t6_rst_rx_data", int'(rx_data), 0);
    wait_cycles(1200);
    check("t6_no_frame_after_rst", frames_seen - f0, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
